// File: rtl/lc3b_control_full_pkg.sv
// Shared LC-3b types for the multicycle controller: opcodes, ALU ops,
// byte-lane masks and datapath mux-select encodings.
package lc3b_control_full_pkg;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    // alu_shf: datapath resolves the shift kind from IR[5:4]
    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_shf  = 3'd4
    } lc3b_aluop;

    typedef logic [1:0] lc3b_mem_wmask;

    typedef enum logic [1:0] {
        pcmux_pc2  = 2'd0,
        pcmux_off9 = 2'd1,
        pcmux_alu  = 2'd2,
        pcmux_mdr  = 2'd3
    } pcmux_t;

    typedef enum logic [1:0] {
        marmux_alu  = 2'd0,
        marmux_pc   = 2'd1,
        marmux_mdr  = 2'd2,
        marmux_trap = 2'd3
    } marmux_t;

    typedef enum logic [1:0] {
        rfmux_alu      = 2'd0,
        rfmux_mdr      = 2'd1,
        rfmux_pc       = 2'd2,
        rfmux_mdr_byte = 2'd3
    } regfilemux_t;

    typedef enum logic [1:0] {
        alumux_sr2  = 2'd0,
        alumux_off6 = 2'd1,
        alumux_imm5 = 2'd2,
        alumux_off9 = 2'd3
    } alumux_t;

    function automatic lc3b_mem_wmask byte_lane(input logic lsb);
        return lsb ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lc3b_control_full_if.sv
// Controller <-> datapath/memory bundle; master is the control FSM.
interface lc3b_control_full_if;
    import lc3b_control_full_pkg::*;

    lc3b_opcode    opcode;
    logic          br_en;
    logic          mar_lsb;
    logic          mem_resp;
    logic          load_pc, load_ir, load_mar, load_mdr, load_regfile, load_cc;
    pcmux_t        pcmux_sel;
    marmux_t       marmux_sel;
    logic          mdrmux_sel;
    regfilemux_t   regfilemux_sel;
    alumux_t       alumux_sel;
    logic          storemux_sel, destmux_sel;
    lc3b_aluop     alu_op;
    logic          mem_read, mem_write;
    lc3b_mem_wmask mem_byte_enable;
    logic          halted, err_timeout, err_illegal;

    modport master (
        input  opcode, br_en, mar_lsb, mem_resp,
        output load_pc, load_ir, load_mar, load_mdr, load_regfile, load_cc,
               pcmux_sel, marmux_sel, mdrmux_sel, regfilemux_sel, alumux_sel,
               storemux_sel, destmux_sel, alu_op, mem_read, mem_write,
               mem_byte_enable, halted, err_timeout, err_illegal
    );

    modport slave (
        output opcode, br_en, mar_lsb, mem_resp,
        input  load_pc, load_ir, load_mar, load_mdr, load_regfile, load_cc,
               pcmux_sel, marmux_sel, mdrmux_sel, regfilemux_sel, alumux_sel,
               storemux_sel, destmux_sel, alu_op, mem_read, mem_write,
               mem_byte_enable, halted, err_timeout, err_illegal
    );

endinterface

// File: rtl/lc3b_control_full_mem_watchdog.sv
// Memory-wait watchdog: counts unanswered wait cycles, flags expiry at TIMEOUT.
module lc3b_control_full_mem_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic expired
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // expired is raised during the TIMEOUT-th unanswered wait cycle
    assign expired = (TIMEOUT != 0) && waiting && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (waiting && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/lc3b_control_full.sv
// Multicycle LC-3b control FSM: fetch/decode/execute sequencing, memory
// handshake with watchdog, sticky halt on illegal opcode or memory timeout.
module lc3b_control_full
    import lc3b_control_full_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int EN_BYTE     = 1,
    parameter int EN_INDIRECT = 1
) (
    input logic clk,
    input logic reset,
    lc3b_control_full_if.master bus
);
    typedef enum logic [4:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE, S_ALU, S_SHF, S_BR, S_BR_TAKEN,
        S_JMP, S_JSR, S_LEA, S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ST2,
        S_IND1, S_IND2, S_TRAP1, S_TRAP2, S_TRAP3, S_HALT
    } state_t;

    state_t state_q, state_d;
    logic   err_timeout_q, err_timeout_d;
    logic   err_illegal_q, err_illegal_d;
    logic   illegal, wd_clear, wd_waiting, wd_expired;

    function automatic logic is_wait(input state_t s);
        return s inside {S_FETCH2, S_IND1, S_LD1, S_ST2, S_TRAP2};
    endfunction

    assign wd_waiting = is_wait(state_q) && !bus.mem_resp;
    assign wd_clear   = is_wait(state_d) && (state_d != state_q);

    lc3b_control_full_mem_watchdog #(.TIMEOUT(MEM_TIMEOUT)) u_mem_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .waiting (wd_waiting),
        .expired (wd_expired)
    );

    always_comb begin
        illegal = 1'b0;
        case (bus.opcode)
            op_rti:         illegal = 1'b1;
            op_ldb, op_stb: illegal = (EN_BYTE == 0);
            op_ldi, op_sti: illegal = (EN_INDIRECT == 0);
            default:        illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH1;
            err_timeout_q <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_timeout_q <= err_timeout_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        err_timeout_d = err_timeout_q;
        err_illegal_d = err_illegal_q;
        case (state_q)
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH3: state_d = S_DECODE;
            S_FETCH2, S_IND1, S_LD1, S_ST2, S_TRAP2: begin
                // a response in the expiry cycle still completes the access
                if (bus.mem_resp) begin
                    case (state_q)
                        S_FETCH2: state_d = S_FETCH3;
                        S_IND1:   state_d = S_IND2;
                        S_LD1:    state_d = S_LD2;
                        S_TRAP2:  state_d = S_TRAP3;
                        default:  state_d = S_FETCH1;
                    endcase
                end else if (wd_expired) begin
                    state_d       = S_HALT;
                    err_timeout_d = 1'b1;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    state_d       = S_HALT;
                    err_illegal_d = 1'b1;
                end else begin
                    case (bus.opcode)
                        op_add, op_and, op_not: state_d = S_ALU;
                        op_shf:                 state_d = S_SHF;
                        op_br:                  state_d = S_BR;
                        op_jmp:                 state_d = S_JMP;
                        op_jsr:                 state_d = S_JSR;
                        op_lea:                 state_d = S_LEA;
                        op_trap:                state_d = S_TRAP1;
                        default:                state_d = S_CALC_ADDR;
                    endcase
                end
            end
            S_CALC_ADDR: begin
                if (bus.opcode inside {op_ldi, op_sti})      state_d = S_IND1;
                else if (bus.opcode inside {op_ldr, op_ldb}) state_d = S_LD1;
                else                                         state_d = S_ST1;
            end
            S_IND2:  state_d = (bus.opcode == op_ldi) ? S_LD1 : S_ST1;
            S_BR:    state_d = bus.br_en ? S_BR_TAKEN : S_FETCH1;
            S_ST1:   state_d = S_ST2;
            S_TRAP1: state_d = S_TRAP2;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH1;
        endcase
    end

    assign bus.err_timeout = err_timeout_q;
    assign bus.err_illegal = err_illegal_q;

    always_comb begin
        bus.load_pc         = 1'b0;
        bus.load_ir         = 1'b0;
        bus.load_mar        = 1'b0;
        bus.load_mdr        = 1'b0;
        bus.load_regfile    = 1'b0;
        bus.load_cc         = 1'b0;
        bus.pcmux_sel       = pcmux_pc2;
        bus.marmux_sel      = marmux_alu;
        bus.mdrmux_sel      = 1'b0;
        bus.regfilemux_sel  = rfmux_alu;
        bus.alumux_sel      = alumux_sr2;
        bus.storemux_sel    = 1'b0;
        bus.destmux_sel     = 1'b0;
        bus.alu_op          = alu_add;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = 2'b11;
        bus.halted          = 1'b0;
        // held reset forces the idle output set regardless of state
        if (!reset) begin
            case (state_q)
                S_FETCH1: begin
                    bus.marmux_sel = marmux_pc;
                    bus.load_mar   = 1'b1;
                    bus.load_pc    = 1'b1;
                end
                S_FETCH2, S_IND1, S_LD1, S_TRAP2: begin
                    bus.mem_read   = 1'b1;
                    bus.mdrmux_sel = 1'b1;
                    bus.load_mdr   = 1'b1;
                end
                S_FETCH3: bus.load_ir = 1'b1;
                S_ALU: begin
                    case (bus.opcode)
                        op_and:  bus.alu_op = alu_and;
                        op_not:  bus.alu_op = alu_not;
                        default: bus.alu_op = alu_add;
                    endcase
                    if (bus.opcode inside {op_add, op_and}) bus.alumux_sel = alumux_imm5;
                    bus.load_regfile = 1'b1;
                    bus.load_cc      = 1'b1;
                end
                S_SHF: begin
                    bus.alu_op       = alu_shf;
                    bus.load_regfile = 1'b1;
                    bus.load_cc      = 1'b1;
                end
                S_BR_TAKEN: begin
                    bus.pcmux_sel = pcmux_off9;
                    bus.load_pc   = 1'b1;
                end
                S_JMP: begin
                    bus.pcmux_sel = pcmux_alu;
                    bus.alu_op    = alu_pass;
                    bus.load_pc   = 1'b1;
                end
                S_JSR: begin
                    bus.destmux_sel    = 1'b1;
                    bus.regfilemux_sel = rfmux_pc;
                    bus.load_regfile   = 1'b1;
                    bus.pcmux_sel      = pcmux_off9;
                    bus.alu_op         = alu_pass;
                    bus.load_pc        = 1'b1;
                end
                S_LEA: begin
                    bus.alumux_sel   = alumux_off9;
                    bus.load_regfile = 1'b1;
                    bus.load_cc      = 1'b1;
                end
                S_CALC_ADDR: begin
                    bus.alumux_sel = alumux_off6;
                    bus.load_mar   = 1'b1;
                end
                S_IND2: begin
                    bus.marmux_sel = marmux_mdr;
                    bus.load_mar   = 1'b1;
                end
                S_LD2: begin
                    bus.regfilemux_sel = (bus.opcode == op_ldb) ? rfmux_mdr_byte : rfmux_mdr;
                    bus.load_regfile   = 1'b1;
                    bus.load_cc        = 1'b1;
                end
                S_ST1: begin
                    bus.storemux_sel = 1'b1;
                    bus.alu_op       = alu_pass;
                    bus.load_mdr     = 1'b1;
                end
                S_ST2: begin
                    bus.mem_write = 1'b1;
                    if (bus.opcode == op_stb) bus.mem_byte_enable = byte_lane(bus.mar_lsb);
                end
                S_TRAP1: begin
                    bus.destmux_sel    = 1'b1;
                    bus.regfilemux_sel = rfmux_pc;
                    bus.load_regfile   = 1'b1;
                    bus.marmux_sel     = marmux_trap;
                    bus.load_mar       = 1'b1;
                end
                S_TRAP3: begin
                    bus.pcmux_sel = pcmux_mdr;
                    bus.load_pc   = 1'b1;
                end
                S_HALT:  bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3b_control_full.sv
// Directed bench: default-parameter controller (a) and a short-timeout,
// byte-disabled controller (b), checked cycle by cycle against hand values.
module tb_lc3b_control_full;
    import lc3b_control_full_pkg::*;

    localparam int LPC  = 'h400, LIR = 'h200, LMAR = 'h100, LMDR = 'h080;
    localparam int LRF  = 'h040, LCC = 'h020, MRD  = 'h010, MWR  = 'h008;
    localparam int HLT  = 'h004, ETO = 'h002, EIL  = 'h001;

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1;
    logic auto_a = 1'b0, man_resp_a = 1'b0, man_resp_b = 1'b0;
    int   n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    lc3b_control_full_if a_if ();
    lc3b_control_full_if b_if ();

    assign a_if.mem_resp = auto_a ? (a_if.mem_read | a_if.mem_write) : man_resp_a;
    assign b_if.mem_resp = man_resp_b;

    lc3b_control_full #(.MEM_TIMEOUT(64), .EN_BYTE(1), .EN_INDIRECT(1)) u_dut_a (
        .clk (clk), .reset (rst_a), .bus (a_if)
    );
    lc3b_control_full #(.MEM_TIMEOUT(4), .EN_BYTE(0), .EN_INDIRECT(1)) u_dut_b (
        .clk (clk), .reset (rst_b), .bus (b_if)
    );

    function automatic int ctl_a();
        return int'({a_if.load_pc, a_if.load_ir, a_if.load_mar, a_if.load_mdr,
                     a_if.load_regfile, a_if.load_cc, a_if.mem_read, a_if.mem_write,
                     a_if.halted, a_if.err_timeout, a_if.err_illegal});
    endfunction

    function automatic int ctl_b();
        return int'({b_if.load_pc, b_if.load_ir, b_if.load_mar, b_if.load_mdr,
                     b_if.load_regfile, b_if.load_cc, b_if.mem_read, b_if.mem_write,
                     b_if.halted, b_if.err_timeout, b_if.err_illegal});
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        a_if.opcode = op_add; a_if.br_en = 1'b0; a_if.mar_lsb = 1'b0;
        b_if.opcode = op_add; b_if.br_en = 1'b0; b_if.mar_lsb = 1'b0;

        // reset state, then reset in the middle of a fetch wait
        step();
        chk("rst_ctl", ctl_a(), 0);
        chk("rst_pcmux", int'(a_if.pcmux_sel), 0);
        chk("rst_aluop", int'(a_if.alu_op), int'(alu_add));
        chk("rst_be", int'(a_if.mem_byte_enable), 3);
        rst_a = 1'b0; #1;
        chk("f1_ctl", ctl_a(), LPC | LMAR);
        step();
        chk("f2_ctl", ctl_a(), MRD | LMDR);
        rst_a = 1'b1;
        step();
        chk("midrst_ctl", ctl_a(), 0);
        rst_a = 1'b0; #1;
        chk("midrst_f1", ctl_a(), LPC | LMAR);
        chk("midrst_marmux", int'(a_if.marmux_sel), int'(marmux_pc));

        // ADD with three unanswered wait cycles, resp on the fourth
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("add_wait%0d", i), ctl_a(), MRD | LMDR);
        end
        chk("add_mdrmux", int'(a_if.mdrmux_sel), 1);
        man_resp_a = 1'b1;
        step(); man_resp_a = 1'b0;
        chk("add_f3", ctl_a(), LIR);
        step();
        chk("add_decode", ctl_a(), 0);
        step();
        chk("add_alu", ctl_a(), LRF | LCC);
        chk("add_alumux", int'(a_if.alumux_sel), int'(alumux_imm5));
        step();
        chk("add_back_f1", ctl_a(), LPC | LMAR);

        auto_a = 1'b1;
        a_if.opcode = op_and; step(4);
        chk("and_aluop", int'(a_if.alu_op), int'(alu_and));
        chk("and_alumux", int'(a_if.alumux_sel), int'(alumux_imm5));
        step();
        a_if.opcode = op_not; step(4);
        chk("not_aluop", int'(a_if.alu_op), int'(alu_not));
        chk("not_alumux", int'(a_if.alumux_sel), int'(alumux_sr2));
        step();

        // branch taken (6 cycles) and not taken (5 cycles)
        a_if.opcode = op_br; a_if.br_en = 1'b1; step(4);
        chk("br_state", ctl_a(), 0);
        step();
        chk("brt_ctl", ctl_a(), LPC);
        chk("brt_pcmux", int'(a_if.pcmux_sel), int'(pcmux_off9));
        step();
        chk("brt_f1", ctl_a(), LPC | LMAR);
        a_if.br_en = 1'b0; step(5);
        chk("brn_f1", ctl_a(), LPC | LMAR);

        // STB: byte lane follows mar_lsb; STR writes both lanes
        a_if.opcode = op_stb; a_if.mar_lsb = 1'b1; step(4);
        chk("stb_calc", ctl_a(), LMAR);
        chk("stb_alumux", int'(a_if.alumux_sel), int'(alumux_off6));
        step();
        chk("stb_st1", ctl_a(), LMDR);
        chk("stb_storemux", int'(a_if.storemux_sel), 1);
        chk("stb_st1_aluop", int'(a_if.alu_op), int'(alu_pass));
        chk("stb_st1_mdrmux", int'(a_if.mdrmux_sel), 0);
        step();
        chk("stb_st2", ctl_a(), MWR);
        chk("stb_be_hi", int'(a_if.mem_byte_enable), 2);
        a_if.mar_lsb = 1'b0; #1;
        chk("stb_be_lo", int'(a_if.mem_byte_enable), 1);
        step();
        chk("stb_f1", ctl_a(), LPC | LMAR);
        a_if.opcode = op_str; a_if.mar_lsb = 1'b1; step(6);
        chk("str_st2", ctl_a(), MWR);
        chk("str_be", int'(a_if.mem_byte_enable), 3);
        step();

        // LDI zero-wait: 9 cycles
        a_if.opcode = op_ldi; step(5);
        chk("ldi_ind1", ctl_a(), MRD | LMDR);
        step();
        chk("ldi_ind2", ctl_a(), LMAR);
        chk("ldi_marmux", int'(a_if.marmux_sel), int'(marmux_mdr));
        step();
        chk("ldi_ld1", ctl_a(), MRD | LMDR);
        step();
        chk("ldi_ld2", ctl_a(), LRF | LCC);
        chk("ldi_rfmux", int'(a_if.regfilemux_sel), int'(rfmux_mdr));
        step();
        chk("ldi_f1", ctl_a(), LPC | LMAR);

        a_if.opcode = op_ldb; step(6);
        chk("ldb_rfmux", int'(a_if.regfilemux_sel), int'(rfmux_mdr_byte));
        step();

        // TRAP: 7 cycles
        a_if.opcode = op_trap; step(4);
        chk("trap1_ctl", ctl_a(), LRF | LMAR);
        chk("trap1_marmux", int'(a_if.marmux_sel), int'(marmux_trap));
        chk("trap1_destmux", int'(a_if.destmux_sel), 1);
        chk("trap1_rfmux", int'(a_if.regfilemux_sel), int'(rfmux_pc));
        step();
        chk("trap2_ctl", ctl_a(), MRD | LMDR);
        step();
        chk("trap3_ctl", ctl_a(), LPC);
        chk("trap3_pcmux", int'(a_if.pcmux_sel), int'(pcmux_mdr));
        step();
        chk("trap_f1", ctl_a(), LPC | LMAR);

        a_if.opcode = op_jsr; step(4);
        chk("jsr_ctl", ctl_a(), LRF | LPC);
        chk("jsr_destmux", int'(a_if.destmux_sel), 1);
        step();

        a_if.opcode = op_rti; step(4);
        chk("rti_halt", ctl_a(), HLT | EIL);
        step(2);
        chk("rti_sticky", ctl_a(), HLT | EIL);

        // controller b: 4-cycle watchdog, byte ops disabled
        rst_b = 1'b0; #1;
        chk("b_f1", ctl_b(), LPC | LMAR);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("b_wait%0d", i), ctl_b(), MRD | LMDR);
        end
        step();
        chk("b_timeout", ctl_b(), HLT | ETO);
        step(3);
        chk("b_timeout_sticky", ctl_b(), HLT | ETO);
        rst_b = 1'b1;
        step();
        chk("b_rst", ctl_b(), 0);
        rst_b = 1'b0; #1;
        chk("b_rst_f1", ctl_b(), LPC | LMAR);
        step(4);
        man_resp_b = 1'b1;
        step(); man_resp_b = 1'b0;
        chk("b_resp_wins", ctl_b(), LIR);
        b_if.opcode = op_ldb;
        step(2);
        chk("b_ldb_illegal", ctl_b(), HLT | EIL);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
